array_lookup_arbiter: RTL and testbench

Shares one fixed-latency, non-stalling array-lookup pipeline (2-bit `sel`, 4×32-bit `arr`, returns `arr[sel+1]` after 3 clock edges) among `NUM_REQ` requesters. The block owns the 4-entry lookup table and a configuration write port, and round-robin arbitrates lookup requests. It issues at most one lookup per cycle and tags each lookup in a shift register matching the pipeline latency, so every result returns to its requester. Out-of-range indices are intercepted before issue and answered with an error flag.

---
 rtl/array_lookup_arbiter.sv | 109 ++++++++++
 tb/tb_array_lookup_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_lookup_arbiter.sv
// Round-robin arbiter sharing one fixed-latency array-lookup pipeline among NUM_REQ requesters.
// Owns the 4-entry lookup table and routes each result back by a tag pipe matched to the pipeline latency.
module array_lookup_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 3,
  parameter int ELEM_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*NUM_REQ-1:0]         req_sel,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_addr,
  input  logic [ELEM_WIDTH-1:0]        cfg_data,
  output logic [1:0]                   lk_sel,
  output logic [4*ELEM_WIDTH-1:0]      lk_arr,
  input  logic [ELEM_WIDTH-1:0]        lk_out,
  output logic                         resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic                         resp_err,
  output logic [ELEM_WIDTH-1:0]        resp_data,
  output logic                         busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [3:0][ELEM_WIDTH-1:0] tbl;
  logic [ID_W-1:0]            last;
  logic                       grant_any;
  logic [ID_W-1:0]            grant_id;
  logic [1:0]                 granted_sel;
  logic                       sel_err;

  logic [LATENCY-1:0]         tag_v;
  logic [ID_W-1:0]            tag_id  [LATENCY];
  logic                       tag_err [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  assign lk_arr = tbl;

  // A table write owns the cycle, so every issued lookup sees a stable table.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    if (!cfg_we) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        idx = (int'(last) + off) % NUM_REQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // The pipeline reads sel+1, so sel=3 would fall off the table.
  assign granted_sel = req_sel[2*int'(grant_id) +: 2];
  assign sel_err     = grant_any && (granted_sel == 2'd3);
  assign lk_sel      = (grant_any && !sel_err) ? granted_sel : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= ID_W'(NUM_REQ - 1);
    end else if (grant_any) begin
      last <= grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i]  <= '0;
        tag_err[i] <= 1'b0;
      end
    end else begin
      tag_v[0]   <= grant_any;
      tag_id[0]  <= grant_id;
      tag_err[0] <= sel_err;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_id[i]  <= tag_id[i-1];
        tag_err[i] <= tag_err[i-1];
      end
    end
  end

  // lk_out is unreset downstream, so it is only passed through under a live tag.
  assign resp_valid = tag_v[LATENCY-1];
  assign resp_id    = resp_valid ? tag_id[LATENCY-1] : '0;
  assign resp_err   = resp_valid ? tag_err[LATENCY-1] : 1'b0;
  assign resp_data  = (resp_valid && !tag_err[LATENCY-1]) ? lk_out : '0;
  assign busy       = |tag_v;

endmodule

// File: tb/tb_array_lookup_arbiter.sv
// Directed bench for array_lookup_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_array_lookup_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [7:0]   req_sel;
  logic [3:0]   req_ready;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [31:0]  cfg_data;
  logic [1:0]   lk_sel;
  logic [127:0] lk_arr;
  logic [31:0]  lk_out;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic         resp_err;
  logic [31:0]  resp_data;
  logic         busy;

  array_lookup_arbiter #(.NUM_REQ(4), .LATENCY(3), .ELEM_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .lk_sel(lk_sel), .lk_arr(lk_arr), .lk_out(lk_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .resp_data(resp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unreset 3-stage lookup pipeline returning arr[sel+1].
  logic [31:0] p0, p1, p2;
  function automatic logic [31:0] pick(input logic [127:0] arr, input logic [1:0] sel);
    case (sel)
      2'd0:    pick = arr[63:32];
      2'd1:    pick = arr[95:64];
      2'd2:    pick = arr[127:96];
      default: pick = 32'hDEAD_BEEF;
    endcase
  endfunction
  always @(posedge clk) begin
    p0 <= pick(lk_arr, lk_sel);
    p1 <= p0;
    p2 <= p1;
  end
  assign lk_out = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic [1:0] id, input logic err, input logic [31:0] data);
    exp_t e;
    e.id = id; e.err = err; e.data = data; e.due = cyc + 3;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got id=%0d err=%0d data=%0h at cyc %0d, none expected",
                 resp_id, resp_err, resp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resp_id !== e.id || resp_err !== e.err || resp_data !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL resp: got id=%0d err=%0d data=%0h cyc=%0d expected id=%0d err=%0d data=%0h cyc=%0d",
                   resp_id, resp_err, resp_data, cyc, e.id, e.err, e.data, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 128'(sb.size()), 128'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

    rst = 1'b1; req_valid = '0; req_sel = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp_valid", 128'(resp_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_table", lk_arr, 128'd0);
    check("reset_ready", 128'(req_ready), 128'd0);
    rst = 1'b0;
    tick();

    // Table load then single lookup from requester 2.
    for (int k = 0; k < 4; k++) begin
      cfg_we = 1'b1; cfg_addr = 2'(k); cfg_data = vals[k];
      tick();
    end
    cfg_we = 1'b0;
    check("table_load", lk_arr, {32'h44, 32'h33, 32'h22, 32'h11});
    req_valid = 4'b0100; req_sel = 8'b00_01_00_00;
    #1;
    check("single_ready", 128'(req_ready), 128'b0100);
    check("single_lk_sel", 128'(lk_sel), 128'd1);
    expect_resp(2'd2, 1'b0, 32'h33);
    tick();

    // Requester 3 alone, which also leaves the pointer at 3.
    req_valid = 4'b1000; req_sel = 8'b10_00_00_00;
    #1;
    check("req3_ready", 128'(req_ready), 128'b1000);
    check("req3_lk_sel", 128'(lk_sel), 128'd2);
    expect_resp(2'd3, 1'b0, 32'h44);
    tick();

    // Round-robin with everyone asking.
    req_valid = 4'b1111; req_sel = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_ready_%0d", i), 128'(req_ready), 128'(4'b0001 << (i % 4)));
      expect_resp(2'(i % 4), 1'b0, 32'h22);
      tick();
    end

    // Out-of-range index.
    req_valid = 4'b0010; req_sel = 8'b00_00_11_00;
    #1;
    check("oor_ready", 128'(req_ready), 128'b0010);
    check("oor_lk_sel", 128'(lk_sel), 128'd0);
    expect_resp(2'd1, 1'b1, 32'h0);
    tick();

    // Config write blocks the grant for one cycle.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'hAA;
    req_valid = 4'b0001; req_sel = 8'h00;
    #1;
    check("cfg_block_ready", 128'(req_ready), 128'd0);
    check("cfg_block_lk_sel", 128'(lk_sel), 128'd0);
    tick();
    cfg_we = 1'b0;
    #1;
    check("cfg_after_ready", 128'(req_ready), 128'b0001);
    expect_resp(2'd0, 1'b0, 32'h22);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    // Write lands in the same cycle the 0x22 response emerges.
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 32'hBB;
    tick();
    cfg_we = 1'b0;
    req_valid = 4'b0001; req_sel = 8'h00;
    #1;
    check("bb_ready", 128'(req_ready), 128'b0001);
    expect_resp(2'd0, 1'b0, 32'hBB);
    tick();
    req_valid = 4'b0000;
    drain("drain_main");

    // Reset with tags in flight: nothing may come back.
    req_valid = 4'b0111; req_sel = 8'h00;
    #1;
    check("mid_grant1", 128'(req_ready), 128'b0010);
    tick();
    check("mid_grant2", 128'(req_ready), 128'b0100);
    tick();
    rst = 1'b1;
    #1;
    check("mid_busy_in_reset", 128'(busy), 128'd0);
    tick();
    rst = 1'b0;
    req_valid = 4'b0000;
    repeat (5) tick();
    check("mid_busy_after", 128'(busy), 128'd0);
    check("mid_table_cleared", lk_arr, 128'd0);
    req_valid = 4'b1111;
    #1;
    check("mid_next_grant", 128'(req_ready), 128'b0001);
    expect_resp(2'd0, 1'b0, 32'h0);
    tick();
    req_valid = 4'b0000;
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
